lwir_ul0304_emulator: RTL and testbench

//  Synthesizable model of the UL0304 LWIR sensor, sitting at the far end of the lwir_ul0304 interface.
//  It consumes the syt/syl/syp timing driven by the capture path and returns 8-bit pixels on datain.
//  A deterministic test pattern lets the capture, DMA and HPS software chain be exercised without a physical sensor.
//  It is instantiated in loopback builds in place of the sensor pins.

---
 rtl/lwir_pkg.sv | 16 +
 rtl/lwir_pattern_gen.sv | 46 ++++
 rtl/lwir_ul0304_emulator.sv | 157 +++++++++++++++
 tb/tb_lwir_ul0304_emulator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwir_pkg.sv
// Shared UL0304 definitions: sensor geometry, pattern selector and emulator FSM states.
package lwir_pkg;

  localparam int unsigned UL0304_COLS = 384;
  localparam int unsigned UL0304_ROWS = 288;

  typedef enum logic [1:0] {PAT_RAMP, PAT_FRAME, PAT_CHECK, PAT_LFSR} pattern_e;

  typedef enum logic [1:0] {IDLE, WAIT_L, LINE} state_e;

  // x^8+x^6+x^5+x^4+1, shifting left with the feedback bit entering at bit 0
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/lwir_pattern_gen.sv
// Test-pattern source for the UL0304 emulator: combinational pixel function plus the LFSR state.
module lwir_pattern_gen
  import lwir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROW_W  = 9,
  parameter int unsigned COL_W  = 9,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  pattern_e          sel,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [DATA_W-1:0] frame_cnt,
  input  logic              step,
  input  logic              load,
  output logic [DATA_W-1:0] pix
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= SEED;
    end else if (step) begin
      lfsr_q <= lfsr_nx;
    end
  end

  // The pixel emitted on a strobe is the post-step LFSR value, so the first pixel is one step past SEED
  always_comb begin
    lfsr_nx = lfsr8_next(lfsr_q);
    pix     = '0;
    unique case (sel)
      PAT_RAMP:  pix = DATA_W'(row) + DATA_W'(col);
      PAT_FRAME: pix = frame_cnt;
      PAT_CHECK: pix = (col[3] ^ row[3]) ? '1 : '0;
      PAT_LFSR:  pix = DATA_W'(lfsr_nx);
    endcase
  end

endmodule

// File: rtl/lwir_ul0304_emulator.sv
// UL0304 LWIR sensor emulator: follows syt/syl/syp timing from the capture path and
// returns deterministic test-pattern pixels on datain, flagging timing violations.
module lwir_ul0304_emulator
  import lwir_pkg::*;
#(
  parameter int unsigned COLS   = UL0304_COLS,
  parameter int unsigned ROWS   = UL0304_ROWS,
  parameter int unsigned DATA_W = 8,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  input  logic              syt,
  input  logic              syl,
  input  logic              syp,
  output logic [DATA_W-1:0] datain,
  output logic [15:0]       frame_cnt,
  output logic              err_resync,
  output logic              err_short,
  output logic              err_overrun,
  input  logic              err_clr
);

  localparam int unsigned COL_W = ($clog2(COLS + 1) < 4) ? 4 : $clog2(COLS + 1);
  localparam int unsigned ROW_W = ($clog2(ROWS + 1) < 4) ? 4 : $clog2(ROWS + 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(COLS);
  localparam logic [COL_W-1:0] COL_END  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROWS - 1);

  state_e           state;
  pattern_e         sel_q;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             syt_q, syl_q, syp_q;
  logic             syt_p, syl_p, syp_p;
  logic             syt_rise, syl_rise, syp_rise;
  logic             set_resync, set_short, set_overrun;
  logic             gen_step, gen_load;
  logic [DATA_W-1:0] pix;

  always_comb begin
    syt_rise    = syt_q & ~syt_p;
    syl_rise    = syl_q & ~syl_p;
    syp_rise    = syp_q & ~syp_p;
    set_resync  = enable && syt_rise && (state != IDLE);
    set_short   = enable && !syt_rise && (state == LINE) && syl_rise && (col != COL_FULL);
    set_overrun = enable && !syt_rise && (state == WAIT_L) && !syl_rise && syp_rise
                  && (col == COL_FULL);
    gen_load    = enable && syt_rise;
    gen_step    = enable && !syt_rise && (state == LINE) && !syl_rise && syp_rise;
  end

  lwir_pattern_gen #(
    .DATA_W (DATA_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .SEED   (SEED)
  ) u_pattern_gen (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel_q),
    .row       (row),
    .col       (col),
    .frame_cnt (frame_cnt[DATA_W-1:0]),
    .step      (gen_step),
    .load      (gen_load),
    .pix       (pix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_q       <= PAT_RAMP;
      col         <= '0;
      row         <= '0;
      datain      <= '0;
      frame_cnt   <= '0;
      err_resync  <= 1'b0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
      syt_q       <= 1'b0;
      syl_q       <= 1'b0;
      syp_q       <= 1'b0;
      syt_p       <= 1'b0;
      syl_p       <= 1'b0;
      syp_p       <= 1'b0;
    end else begin
      syt_q <= syt;
      syl_q <= syl;
      syp_q <= syp;
      syt_p <= syt_q;
      syl_p <= syl_q;
      syp_p <= syp_q;

      // A new error in the same cycle as err_clr leaves the flag set
      err_resync  <= set_resync  | (err_resync  & ~err_clr);
      err_short   <= set_short   | (err_short   & ~err_clr);
      err_overrun <= set_overrun | (err_overrun & ~err_clr);

      if (!enable) begin
        state  <= IDLE;
        datain <= '0;
        col    <= '0;
        row    <= '0;
      end else if (syt_rise) begin
        // Frame (re)start; a coincident syl rise opens line 0 immediately
        sel_q <= pattern_e'(pattern_sel);
        row   <= '0;
        col   <= '0;
        state <= syl_rise ? LINE : WAIT_L;
      end else begin
        unique case (state)
          IDLE: ;
          WAIT_L: begin
            if (syl_rise) begin
              col   <= '0;
              state <= LINE;
            end else if (syp_rise && (col == COL_FULL)) begin
              datain <= '0;
            end
          end
          LINE: begin
            if (syl_rise) begin
              col <= '0;
              if (row == ROW_END) begin
                row       <= '0;
                frame_cnt <= frame_cnt + 16'd1;
                state     <= IDLE;
              end else begin
                row <= row + 1'b1;
              end
            end else if (syp_rise) begin
              datain <= pix;
              if (col == COL_END) begin
                col <= COL_FULL;
                if (row == ROW_END) begin
                  row       <= '0;
                  frame_cnt <= frame_cnt + 16'd1;
                  state     <= IDLE;
                end else begin
                  row   <= row + 1'b1;
                  state <= WAIT_L;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lwir_ul0304_emulator.sv
// Self-checking bench for lwir_ul0304_emulator: constant vector table, randomized frames
// against a bit-stream reference model, and hand-written error / reset sequences.
module tb_lwir_ul0304_emulator;

  localparam int unsigned COLS = 384;
  localparam int unsigned ROWS = 11;
  localparam int unsigned NBITS = 4400;

  logic        clk = 1'b0;
  logic        reset, enable, err_clr, syt, syl, syp;
  logic [1:0]  pattern_sel;
  logic [7:0]  datain;
  logic [15:0] frame_cnt;
  logic        err_resync, err_short, err_overrun;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0] cap [4][ROWS][COLS];
  bit         lb [NBITS];
  int         frames = 0;

  typedef struct {
    int         sel;
    int         row;
    int         col;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  lwir_ul0304_emulator #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .DATA_W (8),
    .SEED   (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .syt         (syt),
    .syl         (syl),
    .syp         (syp),
    .datain      (datain),
    .frame_cnt   (frame_cnt),
    .err_resync  (err_resync),
    .err_short   (err_short),
    .err_overrun (err_overrun),
    .err_clr     (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Register contents after k steps = bits k..k+7 of the LFSR output stream, oldest bit as MSB
  function automatic logic [7:0] lfsr_state(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = lb[k+i];
    return v;
  endfunction

  function automatic logic [7:0] exp_pix(input int sel, input int r, input int c,
                                         input int fr, input int k);
    case (sel)
      0:       return 8'((r + c) % 256);
      1:       return 8'(fr % 256);
      2:       return (((c / 8) % 2) != ((r / 8) % 2)) ? 8'hFF : 8'h00;
      default: return lfsr_state(k + 1);
    endcase
  endfunction

  task automatic pulse_syt(input bit with_syl);
    syt = 1'b1; syl = with_syl;
    @(negedge clk); syt = 1'b0; syl = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_syl();
    syl = 1'b1;
    @(negedge clk); syl = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic send_pix(output logic [7:0] d);
    syp = 1'b1;
    @(negedge clk); syp = 1'b0;
    @(negedge clk); d = datain;
  endtask

  task automatic run_frame(input int sel);
    logic [7:0] d;
    pattern_sel = 2'(sel);
    pulse_syt(1'b0);
    for (int r = 0; r < int'(ROWS); r++) begin
      pulse_syl();
      for (int c = 0; c < int'(COLS); c++) begin
        send_pix(d);
        cap[sel][r][c] = d;
      end
    end
    frames++;
  endtask

  task automatic run_random_frame(input int sel);
    logic [7:0] d;
    int k = 0;
    int len;
    bit any_short = 1'b0;
    pattern_sel = 2'(sel);
    pulse_syt(1'b0);
    for (int r = 0; r < int'(ROWS); r++) begin
      pulse_syl();
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, COLS - 1)) : int'(COLS);
      if (len < int'(COLS)) any_short = 1'b1;
      for (int c = 0; c < len; c++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        send_pix(d);
        check($sformatf("rand_pix s%0d r%0d c%0d", sel, r, c), 32'(d),
              32'(exp_pix(sel, r, c, frames, k)));
        k++;
      end
      if (r == int'(ROWS) - 1 && len < int'(COLS)) pulse_syl();
    end
    frames++;
    check("rand_frame_cnt", 32'(frame_cnt), 32'(frames));
    check("rand_err_short", 32'(err_short), 32'(any_short));
    check("rand_err_resync", 32'(err_resync), 32'd0);
    pulse_clr();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] seed;
    logic [7:0] first3 [3];

    seed = 8'hA5;
    for (int i = 0; i < 8; i++) lb[i] = seed[7-i];
    for (int n = 0; n + 8 < int'(NBITS); n++) lb[n+8] = lb[n] ^ lb[n+2] ^ lb[n+3] ^ lb[n+4];

    tbl.push_back('{0, 0,   0, 8'h00});
    tbl.push_back('{0, 0, 127, 8'h7F});
    tbl.push_back('{0, 0, 128, 8'h80});
    tbl.push_back('{0, 0, 255, 8'hFF});
    tbl.push_back('{0, 0, 256, 8'h00});
    tbl.push_back('{0, 0, 383, 8'h7F});
    tbl.push_back('{0, 10, 383, 8'h89});
    tbl.push_back('{2, 0,   0, 8'h00});
    tbl.push_back('{2, 0,   7, 8'h00});
    tbl.push_back('{2, 0,   8, 8'hFF});
    tbl.push_back('{2, 0,  15, 8'hFF});
    tbl.push_back('{2, 0,  16, 8'h00});
    tbl.push_back('{2, 8,   0, 8'hFF});
    tbl.push_back('{2, 8,   8, 8'h00});
    tbl.push_back('{3, 0,   0, 8'h4A});
    tbl.push_back('{3, 0,   1, 8'h95});
    tbl.push_back('{3, 0,   2, 8'h2A});

    reset = 1'b1; enable = 1'b0; err_clr = 1'b0;
    syt = 1'b0; syl = 1'b0; syp = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_datain", 32'(datain), 32'h0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'h0);
    check("reset_errs", 32'({err_resync, err_short, err_overrun}), 32'h0);
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);

    run_frame(0);
    check("ramp_frame_cnt", 32'(frame_cnt), 32'd1);
    check("ramp_errs", 32'({err_resync, err_short, err_overrun}), 32'h0);

    run_frame(2);
    check("check_frame_cnt", 32'(frame_cnt), 32'd2);

    run_frame(3);
    for (int i = 0; i < 3; i++) first3[i] = cap[3][0][i];
    run_frame(3);
    for (int i = 0; i < 3; i++)
      check($sformatf("lfsr_repeat_%0d", i), 32'(cap[3][0][i]), 32'(first3[i]));
    check("lfsr_frame_cnt", 32'(frame_cnt), 32'd4);

    foreach (tbl[i])
      check($sformatf("vec%0d s%0d r%0d c%0d", i, tbl[i].sel, tbl[i].row, tbl[i].col),
            32'(cap[tbl[i].sel][tbl[i].row][tbl[i].col]), 32'(tbl[i].exp));

    run_random_frame(1);
    run_random_frame(int'($urandom_range(0, 3)));

    // Short line, clear, overrun coinciding with err_clr
    pattern_sel = 2'd0;
    pulse_syt(1'b0);
    pulse_syl();
    for (int c = 0; c < 100; c++) send_pix(d);
    check("short_pix99", 32'(d), 32'd99);
    check("short_before", 32'(err_short), 32'd0);
    pulse_syl();
    check("short_set", 32'(err_short), 32'd1);
    send_pix(d);
    check("short_next_row", 32'(d), 32'd1);
    pulse_clr();
    check("short_cleared", 32'(err_short), 32'd0);
    for (int c = 1; c < int'(COLS); c++) send_pix(d);
    check("row1_last", 32'(d), 32'h80);
    check("overrun_before", 32'(err_overrun), 32'd0);
    syp = 1'b1;
    @(negedge clk); syp = 1'b0; err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("overrun_wins_clr", 32'(err_overrun), 32'd1);
    check("overrun_datain", 32'(datain), 32'h00);

    // Advance to row 10 and resync with a coincident syl
    for (int r = 2; r < 10; r++) begin
      pulse_syl();
      for (int c = 0; c < int'(COLS); c++) send_pix(d);
    end
    pulse_syl();
    send_pix(d);
    check("row10_pix0", 32'(d), 32'd10);
    for (int c = 1; c < 5; c++) send_pix(d);
    pulse_syt(1'b1);
    check("resync_set", 32'(err_resync), 32'd1);
    check("resync_frame_cnt", 32'(frame_cnt), 32'(frames));
    send_pix(d);
    check("resync_row0_col0", 32'(d), 32'd0);
    send_pix(d);
    check("resync_row0_col1", 32'(d), 32'd1);

    enable = 1'b0;
    @(negedge clk);
    check("disable_datain", 32'(datain), 32'h0);
    check("disable_frame_cnt", 32'(frame_cnt), 32'(frames));
    check("disable_errs_kept", 32'({err_resync, err_overrun}), 32'h3);
    enable = 1'b1;
    pulse_clr();
    check("clr_all", 32'({err_resync, err_short, err_overrun}), 32'h0);
    run_frame(0);
    check("clean_frame_cnt", 32'(frame_cnt), 32'(frames));
    check("clean_errs", 32'({err_resync, err_short, err_overrun}), 32'h0);
    check("clean_pix_r3c5", 32'(cap[0][3][5]), 32'd8);

    // Asynchronous reset mid-line
    pulse_syt(1'b0);
    pulse_syl();
    for (int c = 0; c < 10; c++) send_pix(d);
    check("pre_reset_pix", 32'(d), 32'd9);
    reset = 1'b1;
    #1;
    check("async_reset_datain", 32'(datain), 32'h0);
    check("async_reset_frame_cnt", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
